wb_regfile_unit: RTL and testbench

Parametrised write-back stage with an integrated register file. It latches the MEM-stage result into a WB pipeline register, then selects ALU or load data. Load data is aligned and sign/zero-extended. The stage commits one write per instruction to an internal register file, which has two combinational read ports with write-first bypass. It sits between the memory-access stage and the decode stage's operand read.

---
 rtl/wb_regfile_unit.sv | 195 +++++++++++++++++++
 tb/tb_wb_regfile_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_regfile_unit                                            |
// | Description : Write-back stage with integrated register file. Captures   |
// |               the MEM-stage result into a WB pipeline register, selects  |
// |               ALU or aligned/extended load data, commits one write per   |
// |               instruction and serves two combinational read ports with   |
// |               write-first bypass.                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk               in   clock, rising edge                              |
// |   rst               in   asynchronous reset, active low                  |
// |   stall             in   hold WB register, suppress commit               |
// |   flush             in   squash the instruction being captured           |
// |   in_valid          in   MEM-stage instruction valid                     |
// |   final_result      in   ALU/forwarded result                            |
// |   mem_data          in   raw data-memory word                            |
// |   mem_to_reg        in   1 = write load data, 0 = write final_result     |
// |   load_type         in   0 word, 1 byte s, 2 byte u, 3 half s, 4 half u  |
// |   byte_off          in   low address bits of the load                    |
// |   write_reg_out     in   destination register                            |
// |   reg_write_final   in   register write enable                           |
// |   ra1, ra2          in   read addresses                                  |
// |   rd1, rd2          out  read data                                       |
// |   wb_valid          out  WB register holds a valid instruction           |
// |   reg_write_to_file out  commit write at the next rising edge            |
// |   reg_write_addr    out  commit address                                  |
// |   reg_write_data    out  commit data                                     |
// +--------------------------------------------------------------------------+
module wb_regfile_unit #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter bit ZERO_REG_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] final_result,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_to_reg,
   input  logic [2:0]        load_type,
   input  logic [1:0]        byte_off,
   input  logic [ADDR_W-1:0] write_reg_out,
   input  logic              reg_write_final,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              wb_valid,
   output logic              reg_write_to_file,
   output logic [ADDR_W-1:0] reg_write_addr,
   output logic [DATA_W-1:0] reg_write_data
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] LT_WORD   = 3'd0;
   localparam logic [2:0] LT_BYTE_S = 3'd1;
   localparam logic [2:0] LT_BYTE_U = 3'd2;
   localparam logic [2:0] LT_HALF_S = 3'd3;
   localparam logic [2:0] LT_HALF_U = 3'd4;

   // ------------------------------------------------------------------
   // WB pipeline register
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] wb_result;
   logic [DATA_W-1:0] wb_mem_data;
   logic              wb_mem_to_reg;
   logic [2:0]        wb_load_type;
   logic [1:0]        wb_byte_off;
   logic [ADDR_W-1:0] wb_addr;
   logic              wb_we;

   // Stall has priority over flush: a flush arriving while stalled is
   // dropped because nothing is being captured that cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_valid      <= 1'b0;
         wb_result     <= '0;
         wb_mem_data   <= '0;
         wb_mem_to_reg <= 1'b0;
         wb_load_type  <= LT_WORD;
         wb_byte_off   <= 2'd0;
         wb_addr       <= '0;
         wb_we         <= 1'b0;
      end else if (!stall) begin
         wb_valid      <= in_valid & ~flush;
         wb_result     <= final_result;
         wb_mem_data   <= mem_data;
         wb_mem_to_reg <= mem_to_reg;
         wb_load_type  <= load_type;
         wb_byte_off   <= byte_off;
         wb_addr       <= write_reg_out;
         wb_we         <= reg_write_final;
      end
   end

   // ------------------------------------------------------------------
   // Load alignment. Byte/half lanes are always taken from the low 32
   // bits of the memory word, whatever the datapath width; a narrower
   // datapath is zero-padded up to 32 bits for lane selection.
   // ------------------------------------------------------------------
   logic [31:0] low_word;

   generate
      if (DATA_W >= 32) begin : g_low_word_wide
         assign low_word = wb_mem_data[31:0];
      end else begin : g_low_word_narrow
         assign low_word = {{(32-DATA_W){1'b0}}, wb_mem_data};
      end
   endgenerate

   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;
   logic [DATA_W-1:0] load_data;

   always_comb begin
      byte_lane = 8'h00;
      case (wb_byte_off)
         2'd0:    byte_lane = low_word[7:0];
         2'd1:    byte_lane = low_word[15:8];
         2'd2:    byte_lane = low_word[23:16];
         default: byte_lane = low_word[31:24];
      endcase

      // Half loads ignore byte_off[0]; misaligned halves are not split.
      half_lane = wb_byte_off[1] ? low_word[31:16] : low_word[15:0];

      load_data = wb_mem_data;
      case (wb_load_type)
         LT_BYTE_S: load_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
         LT_BYTE_U: load_data = {{(DATA_W-8){1'b0}}, byte_lane};
         LT_HALF_S: load_data = {{(DATA_W-16){half_lane[15]}}, half_lane};
         LT_HALF_U: load_data = {{(DATA_W-16){1'b0}}, half_lane};
         default:   load_data = wb_mem_data;   // word and reserved types
      endcase
   end

   assign reg_write_data = wb_mem_to_reg ? load_data : wb_result;
   assign reg_write_addr = wb_addr;

   // ------------------------------------------------------------------
   // Commit. Gating with ~stall makes a held instruction commit only on
   // its first unstalled cycle, so each instruction writes exactly once.
   // ------------------------------------------------------------------
   logic zero_dest;

   assign zero_dest         = ZERO_REG_EN && (wb_addr == '0);
   assign reg_write_to_file = wb_valid & wb_we & ~stall & ~zero_dest;

   // ------------------------------------------------------------------
   // Register file storage
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] regs [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (reg_write_to_file) begin
         regs[reg_write_addr] <= reg_write_data;
      end
   end

   // ------------------------------------------------------------------
   // Read ports: write-first bypass so a value being committed this
   // cycle is visible to decode without waiting for the storage edge.
   // ------------------------------------------------------------------
   function automatic logic [DATA_W-1:0] read_port(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] stored,
      input logic              commit,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata
   );
      logic [DATA_W-1:0] value;
      value = stored;
      if (commit && (addr == waddr)) begin
         value = wdata;
      end
      if (ZERO_REG_EN && (addr == '0)) begin
         value = '0;
      end
      return value;
   endfunction

   assign rd1 = read_port(ra1, regs[ra1], reg_write_to_file, reg_write_addr, reg_write_data);
   assign rd2 = read_port(ra2, regs[ra2], reg_write_to_file, reg_write_addr, reg_write_data);

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wb_regfile_unit                                         |
// | Description : Directed self-checking bench for wb_regfile_unit. Three    |
// |               instances: default, ZERO_REG_EN=0 and DATA_W=64/ADDR_W=6.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_wb_regfile_unit;

   int errors = 0;
   int checks = 0;

   logic clk = 1'b0;
   logic rst_n;
   logic stall, flush;

   always #5 clk = ~clk;

   // 32-bit stimulus shared by the default and no-zero-register instances
   logic        in_valid, mem_to_reg, reg_write_final;
   logic [31:0] final_result, mem_data;
   logic [2:0]  load_type;
   logic [1:0]  byte_off;
   logic [4:0]  write_reg_out, ra1, ra2;

   logic [31:0] rd1, rd2, rwd;
   logic        wb_valid, rwtf;
   logic [4:0]  rwa;

   logic [31:0] nz_rd1, nz_rd2, nz_rwd;
   logic        nz_wb_valid, nz_rwtf;
   logic [4:0]  nz_rwa;

   // 64-bit instance
   logic        w_in_valid, w_mem_to_reg, w_reg_write_final;
   logic [63:0] w_final_result, w_mem_data;
   logic [2:0]  w_load_type;
   logic [1:0]  w_byte_off;
   logic [5:0]  w_write_reg_out, w_ra1, w_ra2;
   logic [63:0] w_rd1, w_rd2, w_rwd;
   logic        w_wb_valid, w_rwtf;
   logic [5:0]  w_rwa;

   wb_regfile_unit dut (
      .clk(clk), .rst(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .final_result(final_result), .mem_data(mem_data), .mem_to_reg(mem_to_reg),
      .load_type(load_type), .byte_off(byte_off), .write_reg_out(write_reg_out),
      .reg_write_final(reg_write_final), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .wb_valid(wb_valid), .reg_write_to_file(rwtf), .reg_write_addr(rwa),
      .reg_write_data(rwd)
   );

   wb_regfile_unit #(.ZERO_REG_EN(1'b0)) dut_nz (
      .clk(clk), .rst(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .final_result(final_result), .mem_data(mem_data), .mem_to_reg(mem_to_reg),
      .load_type(load_type), .byte_off(byte_off), .write_reg_out(write_reg_out),
      .reg_write_final(reg_write_final), .ra1(ra1), .ra2(ra2), .rd1(nz_rd1), .rd2(nz_rd2),
      .wb_valid(nz_wb_valid), .reg_write_to_file(nz_rwtf), .reg_write_addr(nz_rwa),
      .reg_write_data(nz_rwd)
   );

   wb_regfile_unit #(.DATA_W(64), .ADDR_W(6)) dut_w (
      .clk(clk), .rst(rst_n), .stall(stall), .flush(flush), .in_valid(w_in_valid),
      .final_result(w_final_result), .mem_data(w_mem_data), .mem_to_reg(w_mem_to_reg),
      .load_type(w_load_type), .byte_off(w_byte_off), .write_reg_out(w_write_reg_out),
      .reg_write_final(w_reg_write_final), .ra1(w_ra1), .ra2(w_ra2), .rd1(w_rd1), .rd2(w_rd2),
      .wb_valid(w_wb_valid), .reg_write_to_file(w_rwtf), .reg_write_addr(w_rwa),
      .reg_write_data(w_rwd)
   );

   // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input logic [31:0] res, input logic [31:0] md,
                        input logic m2r, input logic [2:0] lt, input logic [1:0] bo,
                        input logic [4:0] wr, input logic we);
      in_valid        = v;
      final_result    = res;
      mem_data        = md;
      mem_to_reg      = m2r;
      load_type       = lt;
      byte_off        = bo;
      write_reg_out   = wr;
      reg_write_final = we;
   endtask

   task automatic idle();
      issue(1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0);
   endtask

   task automatic test_reset();
      // Power-on reset state
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL por_wb_valid: got %b expected 0", wb_valid); end
      checks++; if (rwtf !== 1'b0) begin errors++; $display("FAIL por_write_en: got %b expected 0", rwtf); end
      checks++; if (rwa !== 5'd0) begin errors++; $display("FAIL por_write_addr: got %0d expected 0", rwa); end
      checks++; if (rwd !== 32'h0) begin errors++; $display("FAIL por_write_data: got %h expected 00000000", rwd); end
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Commit reg 4, leave a write to reg 3 pending, then reset mid-stream
      issue(1'b1, 32'h44444444, 32'h0, 1'b0, 3'd0, 2'd0, 5'd4, 1'b1);
      step();
      issue(1'b1, 32'hAAAA5555, 32'h0, 1'b0, 3'd0, 2'd0, 5'd3, 1'b1);
      step();
      checks++; if (rwtf !== 1'b1) begin errors++; $display("FAIL pre_reset_pending: got %b expected 1", rwtf); end
      rst_n = 1'b0;
      idle();
      #1;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
      checks++; if (rwtf !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %b expected 0", rwtf); end
      for (int a = 0; a < 32; a++) begin
         ra1 = 5'(a);
         ra2 = 5'(31 - a);
         #1;
         checks++; if (rd1 !== 32'h0 || rd2 !== 32'h0) begin errors++; $display("FAIL reset_read[%0d]: got %h/%h expected 0/0", a, rd1, rd2); end
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      ra1 = 5'd3;
      ra2 = 5'd4;
      #1;
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_no_late_write: got %h expected 00000000", rd1); end
      checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_cleared_reg4: got %h expected 00000000", rd2); end
   endtask

   task automatic test_alu_bypass();
      issue(1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 3'd0, 2'd0, 5'd7, 1'b1);
      step();
      idle();
      ra1 = 5'd7;
      ra2 = 5'd7;
      #1;
      checks++; if (rwtf !== 1'b1) begin errors++; $display("FAIL alu_write_en: got %b expected 1", rwtf); end
      checks++; if (rwa !== 5'd7) begin errors++; $display("FAIL alu_write_addr: got %0d expected 7", rwa); end
      checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_bypass_rd1: got %h expected deadbeef", rd1); end
      checks++; if (rd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_bypass_rd2: got %h expected deadbeef", rd2); end
      step();
      checks++; if (wb_valid !== 1'b0 || rwtf !== 1'b0) begin errors++; $display("FAIL alu_after_idle: got valid=%b we=%b expected 0/0", wb_valid, rwtf); end
      checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_storage_rd1: got %h expected deadbeef", rd1); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  lt  [8];
      logic [1:0]  bo  [8];
      logic [31:0] exp [8];
      lt  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd7, 3'd3};
      bo  = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd3};
      exp = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080FF,
              32'h80FF7F01, 32'hFFFFFFFF, 32'h80FF7F01, 32'hFFFF80FF};
      // Back-to-back loads: each edge captures a new one and commits the previous
      for (int i = 0; i < 8; i++) begin
         issue(1'b1, 32'h11111111, 32'h80FF7F01, 1'b1, lt[i], bo[i], 5'(10 + i), 1'b1);
         step();
         checks++; if (rwd !== exp[i] || rwtf !== 1'b1) begin errors++; $display("FAIL load_ext[%0d]: got %h we=%b expected %h we=1", i, rwd, rwtf, exp[i]); end
      end
      idle();
      step();
      for (int i = 0; i < 8; i++) begin
         ra1 = 5'(10 + i);
         ra2 = 5'(17 - i);
         #1;
         checks++; if (rd1 !== exp[i] || rd2 !== exp[7 - i]) begin errors++; $display("FAIL load_readback[%0d]: got %h/%h expected %h/%h", i, rd1, rd2, exp[i], exp[7 - i]); end
      end
   endtask

   task automatic test_zero_reg();
      issue(1'b1, 32'h12345678, 32'h0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b1);
      step();
      idle();
      ra1 = 5'd0;
      ra2 = 5'd0;
      #1;
      checks++; if (rwtf !== 1'b0) begin errors++; $display("FAIL zero_write_en: got %b expected 0", rwtf); end
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL zero_read_bypass: got %h expected 00000000", rd1); end
      checks++; if (nz_rwtf !== 1'b1) begin errors++; $display("FAIL nz_write_en: got %b expected 1", nz_rwtf); end
      checks++; if (nz_rd1 !== 32'h12345678) begin errors++; $display("FAIL nz_read_bypass: got %h expected 12345678", nz_rd1); end
      step();
      checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL zero_read_storage: got %h expected 00000000", rd2); end
      checks++; if (nz_rd2 !== 32'h12345678) begin errors++; $display("FAIL nz_read_storage: got %h expected 12345678", nz_rd2); end
   endtask

   task automatic test_stall_flush();
      issue(1'b1, 32'h99990009, 32'h0, 1'b0, 3'd0, 2'd0, 5'd9, 1'b1);
      step();
      // A different write plus flush is offered while stalled; both must be ignored
      stall = 1'b1;
      flush = 1'b1;
      issue(1'b1, 32'hBAD0BAD0, 32'h0, 1'b0, 3'd0, 2'd0, 5'd9, 1'b1);
      ra1 = 5'd9;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (rwtf !== 1'b0 || wb_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got we=%b valid=%b expected 0/1", c, rwtf, wb_valid); end
         checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL stall_no_write[%0d]: got %h expected 00000000", c, rd1); end
         step();
      end
      stall = 1'b0;
      flush = 1'b0;
      idle();
      #1;
      checks++; if (rwtf !== 1'b1 || rwd !== 32'h99990009 || rwa !== 5'd9) begin errors++; $display("FAIL stall_release: got we=%b %0d:%h expected 1 9:99990009", rwtf, rwa, rwd); end
      step();
      checks++; if (rwtf !== 1'b0) begin errors++; $display("FAIL stall_single_write: got %b expected 0", rwtf); end
      checks++; if (rd1 !== 32'h99990009) begin errors++; $display("FAIL stall_committed: got %h expected 99990009", rd1); end

      // Flush on capture
      issue(1'b1, 32'h55556666, 32'h0, 1'b0, 3'd0, 2'd0, 5'd9, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle();
      #1;
      checks++; if (wb_valid !== 1'b0 || rwtf !== 1'b0) begin errors++; $display("FAIL flush_capture: got valid=%b we=%b expected 0/0", wb_valid, rwtf); end
      step();
      checks++; if (rd1 !== 32'h99990009) begin errors++; $display("FAIL flush_reg9: got %h expected 99990009", rd1); end
   endtask

   task automatic test_wide();
      w_in_valid = 1'b1; w_final_result = 64'h0123456789ABCDEF; w_mem_data = 64'h0;
      w_mem_to_reg = 1'b0; w_load_type = 3'd0; w_byte_off = 2'd0;
      w_write_reg_out = 6'd63; w_reg_write_final = 1'b1;
      step();
      w_in_valid = 1'b0;
      w_ra1 = 6'd63;
      w_ra2 = 6'd63;
      #1;
      checks++; if (w_rwtf !== 1'b1 || w_rd1 !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL wide_bypass: got we=%b %h expected 1 0123456789abcdef", w_rwtf, w_rd1); end
      step();
      checks++; if (w_rd1 !== 64'h0123456789ABCDEF || w_rd2 !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL wide_storage: got %h/%h expected 0123456789abcdef", w_rd1, w_rd2); end

      w_in_valid = 1'b1; w_mem_data = 64'h0000000000008000; w_mem_to_reg = 1'b1;
      w_load_type = 3'd1; w_byte_off = 2'd1; w_write_reg_out = 6'd5;
      step();
      checks++; if (w_rwd !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL wide_byte_signed: got %h expected ffffffffffffff80", w_rwd); end
      // Lanes come from the low 32 bits only
      w_mem_data = 64'hFFFFFFFF00008000; w_load_type = 3'd4; w_byte_off = 2'd2;
      step();
      checks++; if (w_rwd !== 64'h0) begin errors++; $display("FAIL wide_half_low32: got %h expected 0000000000000000", w_rwd); end
      w_load_type = 3'd0;
      step();
      checks++; if (w_rwd !== 64'hFFFFFFFF00008000) begin errors++; $display("FAIL wide_word: got %h expected ffffffff00008000", w_rwd); end
      w_in_valid = 1'b0;
      step();
      w_ra1 = 6'd5;
      #1;
      checks++; if (w_rd1 !== 64'hFFFFFFFF00008000) begin errors++; $display("FAIL wide_reg5: got %h expected ffffffff00008000", w_rd1); end
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      idle();
      ra1 = 5'd0; ra2 = 5'd0;
      w_in_valid = 1'b0; w_final_result = 64'h0; w_mem_data = 64'h0; w_mem_to_reg = 1'b0;
      w_load_type = 3'd0; w_byte_off = 2'd0; w_write_reg_out = 6'd0; w_reg_write_final = 1'b0;
      w_ra1 = 6'd0; w_ra2 = 6'd0;
      #2;
      test_reset();
      test_alu_bypass();
      test_load_ext();
      test_zero_reg();
      test_stall_flush();
      test_wide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
